// File: rtl/uart_fpu_pkg.sv
// Shared types and constants for the UART-to-FPU command controller.
// UART_FPU_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
package uart_fpu_pkg;

   localparam int unsigned BYTE_W            = 8;
   localparam int unsigned OPC_W_DEF         = 4;
   localparam int unsigned DATA_W_DEF        = 32;
   localparam int unsigned TIMEOUT_TICKS_DEF = 320;

`ifdef UART_FPU_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = 1 + 2 * (DATA_W_DEF / BYTE_W) + 1;
`else
   localparam int unsigned FRAME_LEN = 1 + 2 * (DATA_W_DEF / BYTE_W);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StGetA,
      StGetB,
      StCheck,
      StIssue
   } state_e;

endpackage

// File: rtl/uart_fpu_cmd_ctrl_if.sv
// FPU command port: opcode plus two operands under a valid/ready handshake.
interface uart_fpu_cmd_ctrl_if #(
   parameter int unsigned OPC_W  = uart_fpu_pkg::OPC_W_DEF,
   parameter int unsigned DATA_W = uart_fpu_pkg::DATA_W_DEF
);

   logic              op_valid;
   logic              op_ready;
   logic [OPC_W-1:0]  opcode;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;

   modport master (
      output op_valid,
      output opcode,
      output operand_a,
      output operand_b,
      input  op_ready
   );

   modport slave (
      input  op_valid,
      input  opcode,
      input  operand_a,
      input  operand_b,
      output op_ready
   );

endinterface

// File: rtl/uart_fpu_timeout.sv
// Saturating inter-byte tick counter; expired_o holds while the count sits at TIMEOUT_TICKS.
module uart_fpu_timeout #(
   parameter int unsigned TIMEOUT_TICKS = 320
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic clr_i,
   input  logic en_i,
   input  logic tick_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_TICKS);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && tick_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/uart_fpu_cmd_ctrl.sv
// Assembles UART bytes into opcode/operand frames and issues them to the FPU.
// Define UART_FPU_CHECKSUM_EN to require a trailing XOR byte per frame.
module uart_fpu_cmd_ctrl
   import uart_fpu_pkg::*;
#(
   parameter int unsigned OPC_W         = OPC_W_DEF,
   parameter int unsigned DATA_W        = DATA_W_DEF,
   parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_stick,
   input  logic [7:0] i_rx_byte,
   input  logic       i_rx_done,
   output logic       o_rx_en,
   output logic       o_rx_hold,
   output logic       o_frame_err,
   output logic       o_busy,
   uart_fpu_cmd_ctrl_if.master cmd
);

   localparam int unsigned NBYTES = DATA_W / BYTE_W;
   localparam int unsigned CNT_W  = $clog2(NBYTES) + 1;
   localparam logic [CNT_W-1:0] LastByte = CNT_W'(NBYTES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  byte_cnt_q;
   logic [OPC_W-1:0]  opcode_q;
   logic [DATA_W-1:0] operand_a_q;
   logic [DATA_W-1:0] operand_b_q;
   logic              op_valid_q;
   logic              rx_en_q;
   logic              rx_hold_q;
   logic              frame_err_q;
`ifdef UART_FPU_CHECKSUM_EN
   logic [7:0]        chk_q;
`endif

   logic opc_ok;
   logic to_clr;
   logic to_en;
   logic to_expired;

   assign opc_ok = ((i_rx_byte >> OPC_W) == 8'h00);
   // Any strobe outside ISSUE is an accepted byte, so it restarts the timeout.
   assign to_clr = (state_q == StIdle) || (state_q == StIssue) || i_rx_done;
   assign to_en  = (state_q == StGetA) || (state_q == StGetB) || (state_q == StCheck);

   uart_fpu_timeout #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .clr_i     (to_clr),
      .en_i      (to_en),
      .tick_i    (i_stick),
      .expired_o (to_expired)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         byte_cnt_q  <= '0;
         opcode_q    <= '0;
         operand_a_q <= '0;
         operand_b_q <= '0;
         op_valid_q  <= 1'b0;
         rx_en_q     <= 1'b1;
         rx_hold_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_FPU_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (i_rx_done) begin
                  if (opc_ok) begin
                     opcode_q   <= i_rx_byte[OPC_W-1:0];
                     byte_cnt_q <= '0;
                     state_q    <= StGetA;
`ifdef UART_FPU_CHECKSUM_EN
                     chk_q      <= i_rx_byte;
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
            end
            StGetA: begin
               if (i_rx_done) begin
                  operand_a_q[BYTE_W*byte_cnt_q +: BYTE_W] <= i_rx_byte;
`ifdef UART_FPU_CHECKSUM_EN
                  chk_q <= chk_q ^ i_rx_byte;
`endif
                  if (byte_cnt_q == LastByte) begin
                     byte_cnt_q <= '0;
                     state_q    <= StGetB;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end else if (to_expired) begin
                  state_q     <= StIdle;
                  frame_err_q <= 1'b1;
               end
            end
            StGetB: begin
               if (i_rx_done) begin
                  operand_b_q[BYTE_W*byte_cnt_q +: BYTE_W] <= i_rx_byte;
`ifdef UART_FPU_CHECKSUM_EN
                  chk_q <= chk_q ^ i_rx_byte;
`endif
                  if (byte_cnt_q == LastByte) begin
                     byte_cnt_q <= '0;
`ifdef UART_FPU_CHECKSUM_EN
                     state_q    <= StCheck;
`else
                     state_q    <= StIssue;
                     op_valid_q <= 1'b1;
                     rx_hold_q  <= 1'b1;
                     rx_en_q    <= 1'b0;
`endif
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end else if (to_expired) begin
                  state_q     <= StIdle;
                  frame_err_q <= 1'b1;
               end
            end
`ifdef UART_FPU_CHECKSUM_EN
            StCheck: begin
               if (i_rx_done) begin
                  if (i_rx_byte == chk_q) begin
                     state_q    <= StIssue;
                     op_valid_q <= 1'b1;
                     rx_hold_q  <= 1'b1;
                     rx_en_q    <= 1'b0;
                  end else begin
                     state_q     <= StIdle;
                     frame_err_q <= 1'b1;
                  end
               end else if (to_expired) begin
                  state_q     <= StIdle;
                  frame_err_q <= 1'b1;
               end
            end
`endif
            StIssue: begin
               // Bytes arriving here are dropped; the receiver is held off.
               if (cmd.op_ready && op_valid_q) begin
                  state_q    <= StIdle;
                  op_valid_q <= 1'b0;
                  rx_hold_q  <= 1'b0;
                  rx_en_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cmd.op_valid  = op_valid_q;
   assign cmd.opcode    = opcode_q;
   assign cmd.operand_a = operand_a_q;
   assign cmd.operand_b = operand_b_q;
   assign o_rx_en       = rx_en_q;
   assign o_rx_hold     = rx_hold_q;
   assign o_frame_err   = frame_err_q;
   assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_fpu_cmd_ctrl.sv
// Self-checking bench for uart_fpu_cmd_ctrl: directed and randomized frames against
// a byte-level frame model; honours UART_FPU_CHECKSUM_EN.
module tb_uart_fpu_cmd_ctrl;

   localparam int unsigned OPC_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TO     = 320;
   localparam int unsigned NB     = DATA_W / 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stick = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_en, rx_hold, frame_err, busy;

   uart_fpu_cmd_ctrl_if #(.OPC_W(OPC_W), .DATA_W(DATA_W)) cmd ();

   uart_fpu_cmd_ctrl #(
      .OPC_W         (OPC_W),
      .DATA_W        (DATA_W),
      .TIMEOUT_TICKS (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_stick     (stick),
      .i_rx_byte   (rx_byte),
      .i_rx_done   (rx_done),
      .o_rx_en     (rx_en),
      .o_rx_hold   (rx_hold),
      .o_frame_err (frame_err),
      .o_busy      (busy),
      .cmd         (cmd)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] frame_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         stick = 1'b1;
         step();
         stick = 1'b0;
         step();
      end
   endtask

   // Reference frame: opcode, then each operand least-significant byte first.
   function automatic void build(input logic [OPC_W-1:0] opc, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b);
      logic [7:0] x;
      frame_q.delete();
      frame_q.push_back(8'(opc));
      for (int i = 0; i < NB; i++) frame_q.push_back(8'(a >> (8 * i)));
      for (int i = 0; i < NB; i++) frame_q.push_back(8'(b >> (8 * i)));
`ifdef UART_FPU_CHECKSUM_EN
      x = 8'h00;
      foreach (frame_q[i]) x ^= frame_q[i];
      frame_q.push_back(x);
`else
      x = 8'h00;
`endif
   endfunction

   task automatic send_frame(input int gap_max);
      foreach (frame_q[i]) begin
         if (gap_max > 0) ticks($urandom_range(0, gap_max));
         send_byte(frame_q[i]);
      end
   endtask

   // Called right after the last byte's edge, with op_ready held low for 'stall' cycles.
   task automatic expect_issue(input string tag, input logic [OPC_W-1:0] opc,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input int stall);
      for (int i = 0; i < stall; i++) begin
         check({tag, " stall valid"}, 64'(cmd.op_valid), 64'd1);
         check({tag, " stall opA"}, 64'(cmd.operand_a), 64'(a));
         check({tag, " stall hold"}, 64'(rx_hold), 64'd1);
         if (i == stall / 2 && stall > 1) begin
            rx_byte = 8'(($urandom & 32'h7) | 32'h80);
            rx_done = 1'b1;
         end
         step();
         rx_done = 1'b0;
      end
      check({tag, " valid"}, 64'(cmd.op_valid), 64'd1);
      check({tag, " opcode"}, 64'(cmd.opcode), 64'(opc));
      check({tag, " opA"}, 64'(cmd.operand_a), 64'(a));
      check({tag, " opB"}, 64'(cmd.operand_b), 64'(b));
      check({tag, " hold"}, 64'(rx_hold), 64'd1);
      check({tag, " rx_en low"}, 64'(rx_en), 64'd0);
      cmd.op_ready = 1'b1;
      step();
      check({tag, " valid drop"}, 64'(cmd.op_valid), 64'd0);
      check({tag, " hold drop"}, 64'(rx_hold), 64'd0);
      check({tag, " rx_en back"}, 64'(rx_en), 64'd1);
      check({tag, " idle"}, 64'(busy), 64'd0);
      check({tag, " no err"}, 64'(frame_err), 64'd0);
   endtask

   task automatic run_frame(input string tag, input logic [OPC_W-1:0] opc,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input int stall, input int gap_max);
      build(opc, a, b);
      cmd.op_ready = (stall == 0);
      send_frame(gap_max);
      expect_issue(tag, opc, a, b, stall);
   endtask

   initial begin
      int seen_err;
      int seen_valid;
      logic [7:0] wrong;
      cmd.op_ready = 1'b1;

      // Reset values
      step();
      check("rst rx_en", 64'(rx_en), 64'd1);
      check("rst hold", 64'(rx_hold), 64'd0);
      check("rst valid", 64'(cmd.op_valid), 64'd0);
      check("rst opcode", 64'(cmd.opcode), 64'd0);
      check("rst opA", 64'(cmd.operand_a), 64'd0);
      check("rst opB", 64'(cmd.operand_b), 64'd0);
      check("rst err", 64'(frame_err), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      step();

      // Reference frame, FPU ready on entry, then with a 5-cycle stall
      run_frame("f1", 4'h1, 32'h3F80_0000, 32'h4000_0000, 0, 0);
      run_frame("f1 stall", 4'h1, 32'h3F80_0000, 32'h4000_0000, 5, 0);
      run_frame("after stall", 4'h9, 32'hDEAD_BEEF, 32'h0123_4567, 0, 0);

      // Bad opcodes are discarded with a single error pulse
      send_byte(8'h80);
      check("badopc err", 64'(frame_err), 64'd1);
      check("badopc busy", 64'(busy), 64'd0);
      step();
      check("badopc err once", 64'(frame_err), 64'd0);
      send_byte(8'(($urandom & 32'hEF) | 32'h10));
      check("badopc2 err", 64'(frame_err), 64'd1);
      step();
      run_frame("after badopc", 4'h3, $urandom, $urandom, 1, 0);

      // Stall after 3 bytes until the timeout fires
      build(4'h5, 32'h1111_2222, 32'h3333_4444);
      cmd.op_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_byte(frame_q[i]);
      ticks(TO - 1);
      check("to pre busy", 64'(busy), 64'd1);
      check("to pre err", 64'(frame_err), 64'd0);
      stick = 1'b1;
      step();
      stick = 1'b0;
      seen_err = 0;
      seen_valid = 0;
      for (int i = 0; i < 4; i++) begin
         if (frame_err) seen_err++;
         if (cmd.op_valid) seen_valid++;
         step();
      end
      check("to err pulses", 64'(seen_err), 64'd1);
      check("to no valid", 64'(seen_valid), 64'd0);
      check("to busy", 64'(busy), 64'd0);
      run_frame("after to", 4'hA, $urandom, $urandom, 0, 0);

      // Reset after byte 6
      build(4'h7, 32'hCAFE_F00D, 32'h5555_AAAA);
      for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
      rst_n = 1'b0;
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst opA", 64'(cmd.operand_a), 64'd0);
      check("midrst opcode", 64'(cmd.opcode), 64'd0);
      check("midrst rx_en", 64'(rx_en), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      run_frame("after midrst", 4'h7, 32'hCAFE_F00D, 32'h5555_AAAA, 0, 0);

      // Reset while the command is waiting: valid must drop without a clock edge
      build(4'h2, 32'h8765_4321, 32'h0F0F_F0F0);
      cmd.op_ready = 1'b0;
      send_frame(0);
      check("issrst valid before", 64'(cmd.op_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("issrst valid async", 64'(cmd.op_valid), 64'd0);
      check("issrst hold", 64'(rx_hold), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      run_frame("after issrst", 4'h2, 32'h8765_4321, 32'h0F0F_F0F0, 2, 0);

`ifdef UART_FPU_CHECKSUM_EN
      // Corrupted checksum byte
      build(4'h1, 32'h3F80_0000, 32'h4000_0000);
      wrong = (frame_q[frame_q.size() - 1] == 8'h08) ? 8'h09 : 8'h08;
      frame_q[frame_q.size() - 1] = wrong;
      cmd.op_ready = 1'b1;
      send_frame(0);
      check("chk err", 64'(frame_err), 64'd1);
      check("chk no valid", 64'(cmd.op_valid), 64'd0);
      check("chk busy", 64'(busy), 64'd0);
      step();
`else
      wrong = 8'h00;
`endif

      // Randomized frames with random inter-byte gaps (below timeout) and stalls
      for (int k = 0; k < 10; k++) begin
         run_frame("rand", 4'($urandom_range(0, 15)), $urandom, $urandom,
                   $urandom_range(0, 4), (k % 3 == 0) ? 60 : 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
